// File: rtl/j1_stack_param.sv
// Parametrised j1 data/return stack: internal pointer, signed per-cycle delta, occupancy and sticky error flags.
// Optional macro J1_STACK_GUARD_EN suppresses pointer/count/memory updates on overflow/underflow cycles.
module j1_stack_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH_L2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [1:0]          delta,
    input  logic                we,
    input  logic [WIDTH-1:0]    wd,
    output logic [WIDTH-1:0]    rd,
    output logic [WIDTH-1:0]    rd_peek,
    output logic [DEPTH_L2-1:0] sp,
    output logic [DEPTH_L2:0]   count,
    output logic                ovf,
    output logic                unf,
    input  logic                flag_clr
);

    localparam int DEPTH = 1 << DEPTH_L2;
    localparam logic signed [DEPTH_L2+1:0] DEPTH_S = (DEPTH_L2+2)'(DEPTH);

    logic [WIDTH-1:0]           mem_q [DEPTH];
    logic [DEPTH_L2-1:0]        sp_q, sp_d;
    logic [DEPTH_L2:0]          count_q, count_d;
    logic                       ovf_q, ovf_d;
    logic                       unf_q, unf_d;

    logic signed [DEPTH_L2+1:0] delta_sext;
    logic signed [DEPTH_L2+1:0] ncount;
    logic [DEPTH_L2-1:0]        nsp;
    logic [DEPTH_L2-1:0]        peek_idx;
    logic                       ovf_evt, unf_evt;
    logic                       suppress;
    logic                       advance;
    logic                       mem_we;

    always_comb begin
        delta_sext = {{DEPTH_L2{delta[1]}}, delta};
        ncount     = signed'({1'b0, count_q}) + delta_sext;
        nsp        = sp_q + delta_sext[DEPTH_L2-1:0];
        peek_idx   = sp_q - {{(DEPTH_L2-1){1'b0}}, 1'b1};
        ovf_evt    = !stall && (ncount > DEPTH_S);
        unf_evt    = !stall && ncount[DEPTH_L2+1];
`ifdef J1_STACK_GUARD_EN
        suppress   = ovf_evt || unf_evt;
`else
        suppress   = 1'b0;
`endif
        advance    = !stall && !suppress;
        mem_we     = advance && we && !reset;
    end

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        if (advance) begin
            sp_d = nsp;
            // Occupancy saturates at both ends; it never wraps with the pointer.
            if (ovf_evt)
                count_d = DEPTH_S[DEPTH_L2:0];
            else if (unf_evt)
                count_d = '0;
            else
                count_d = ncount[DEPTH_L2:0];
        end
        ovf_d = (ovf_q & ~flag_clr) | ovf_evt;
        unf_d = (unf_q & ~flag_clr) | unf_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Contents are not reset; writes land at the post-update pointer.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[nsp] <= wd;
    end

    assign rd      = mem_q[sp_q];
    assign rd_peek = mem_q[peek_idx];
    assign sp      = sp_q;
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule
